mux_arbiter_rr: RTL and testbench
=================================

Name: mux_arbiter_rr

Overview:
- Round-robin scheduler for the 4-to-1, 12-bit output multiplexer.
- Four show-ahead input FIFOs feed the mux; this block pops them.
- Each popped word is steered through the mux and pushed into the downstream FIFO one cycle later.
- Grants are burst-limited, and the block honours downstream almost-full backpressure.

Parameters:
- DATA_W, 12, word width; bits [DATA_W-1:DATA_W-2] are the class field and are passed through untouched.
- BURST, 4, maximum words popped from one port before the grant rotates; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_L  input  1  reset, asynchronous and active-low.
- fifo_empty  input  4  per-port empty flag from the input FIFOs; bit i belongs to port i.
- data_in0  input  DATA_W  head word of input FIFO 0 (show-ahead).
- data_in1  input  DATA_W  head word of input FIFO 1.
- data_in2  input  DATA_W  head word of input FIFO 2.
- data_in3  input  DATA_W  head word of input FIFO 3.
- out_almost_full  input  1  downstream FIFO has at most 1 free slot.
- pop  output  4  one-hot pop strobe to the input FIFOs.
- sel  output  2  current grant, also the mux select.
- data_out  output  DATA_W  registered mux output.
- push_out  output  1  write strobe to the downstream FIFO; qualifies data_out.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=IDLE, ptr=0, grant=0, burst_cnt=0.
  - pop=0, sel=0, data_out=0, push_out=0.
  - Reset asserted mid-burst drops everything immediately. No pop or push may be emitted in the cycle after reset deasserts.
- State IDLE:
  - req = ~fifo_empty.
  - If req!=0 and out_almost_full=0: grant <= first set bit of req, searching ptr, ptr+1, ... mod 4; burst_cnt <= 0; go to SERVE.
  - Otherwise stay in IDLE.
  - pop=0 throughout IDLE.
- State SERVE:
  - pop[grant] = ~fifo_empty[grant] & ~out_almost_full. This is combinational from registered state and inputs; all other pop bits are 0.
  - On a pop: burst_cnt <= burst_cnt+1.
  - Exit to IDLE with ptr <= grant+1 mod 4 when either:
    - fifo_empty[grant]=1, or
    - a pop occurs with burst_cnt==BURST-1.
  - out_almost_full=1 with a non-empty port: hold the state; no pop, no count change, no rotation.
- Rotation:
  - Each grant change costs exactly one IDLE bubble cycle.
  - Maximum throughput is BURST words per BURST+1 cycles when more than one port is busy.
- Datapath:
  - data_out <= data_in[grant] when any pop is asserted; otherwise data_out holds.
  - push_out <= |pop.
  - Latency from pop to push_out is 1 cycle.
  - Payload and class bits are unmodified.
- sel = grant at all times, registered.
- Simultaneous events:
  - A port becoming non-empty while another is being served waits for rotation.
  - fifo_empty and out_almost_full rising in the same cycle: empty takes priority (exit to IDLE).
- Invariants:
  - pop is always one-hot or zero.
  - At most one push per cycle.
  - No pop of an empty FIFO.

Decomposition:
- Shared package mux_pkg holds:
  - NUM_PORTS=4, DATA_W=12, SEL_W=2;
  - state encoding IDLE=1'b0, SERVE=1'b1.
- One natural sub-module: rr_pick, the combinational rotate-and-priority-encode (req[3:0], ptr[1:0] -> grant[1:0], any).

Test Plan:
1. Reset sequence: hold reset_L=0 for 2 cycles with all FIFOs non-empty -> pop=0, push_out=0, data_out=12'h000 during reset and in the first cycle after release.
2. Single word per port: FIFOs 0..3 each hold 12'h001, 12'h402, 12'h803, 12'hC04 -> push_out pulses deliver 12'h001, 12'h402, 12'h803, 12'hC04 in that order; each pop is followed by an IDLE bubble.
3. Burst limit with BURST=4: FIFO0 holds 6 words, FIFO1 holds 2 -> output order is 4 from port 0, 2 from port 1, then the remaining 2 from port 0.
4. Backpressure: assert out_almost_full for 3 cycles mid-burst on port 2 -> pop=0 and burst_cnt frozen for those cycles; no word lost or duplicated; sel stays 2.
5. Wrap-around: ptr=3, only FIFO0 and FIFO3 non-empty -> grant goes to 3 first, then to 0 (ptr wraps 3 -> 0).
6. Async reset mid-SERVE at burst_cnt=2 -> outputs clear immediately, without waiting for clk; after release, arbitration restarts from port 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the round-robin mux scheduler.
package mux_pkg;
  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 12;
  localparam int SEL_W     = 2;
  // Wide enough for any burst limit up to 15.
  localparam int CNT_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;
endpackage

// File: rtl/mux_arbiter_rr_rr_pick.sv
// Rotate-and-priority-encode: first requesting port at or after ptr, wrapping.
module rr_pick
  import mux_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     grant,
  output logic                 any
);

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [SEL_W-1:0]       offset;

  // Rotate req so bit 0 is the port at ptr, then take the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: NUM_PORTS];
    offset  = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = SEL_W'(k);
    end
    // Two-bit addition wraps modulo NUM_PORTS by construction.
    grant = ptr + offset;
    any   = |req;
  end

endmodule

// File: rtl/mux_arbiter_rr.sv
// Round-robin, burst-limited scheduler for the 4-to-1 output mux.
//
// Handshake: a port's word is transferred in any cycle where pop[i]=1; pop[i]
// is only raised when fifo_empty[i]=0 and out_almost_full=0, so the input
// FIFO's "valid" is ~fifo_empty and the downstream "ready" is
// ~out_almost_full. The transferred word appears on data_out one cycle later,
// qualified by push_out.
module mux_arbiter_rr
  import mux_pkg::*;
#(
  parameter int DATA_W = mux_pkg::DATA_W,
  parameter int BURST  = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [DATA_W-1:0]    data_in0,
  input  logic [DATA_W-1:0]    data_in1,
  input  logic [DATA_W-1:0]    data_in2,
  input  logic [DATA_W-1:0]    data_in3,
  input  logic                 out_almost_full,
  output logic [NUM_PORTS-1:0] pop,
  output logic [SEL_W-1:0]     sel,
  output logic [DATA_W-1:0]    data_out,
  output logic                 push_out,
  output state_t               state_dbg,
  output logic [CNT_W-1:0]     burst_cnt_dbg
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] req;
  logic [SEL_W-1:0]    pick_grant;
  logic                pick_any;
  logic                pop_fire;
  logic [DATA_W-1:0]   head;

  assign req = ~fifo_empty;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Mux: head word of the granted port.
  always_comb begin
    head = data_in0;
    case (grant_q)
      2'd0:    head = data_in0;
      2'd1:    head = data_in1;
      2'd2:    head = data_in2;
      default: head = data_in3;
    endcase
  end

  // Next-state, pop strobe and rotation decisions.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    pop      = '0;
    pop_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && !out_almost_full) begin
          grant_d = pick_grant;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        pop_fire     = !fifo_empty[grant_q] && !out_almost_full;
        pop[grant_q] = pop_fire;
        // An empty granted port wins over backpressure: give up the grant.
        if (fifo_empty[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_q + 1'b1;
        end else if (pop_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            ptr_d   = grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: capture the popped word and strobe the downstream push.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      push_out <= 1'b0;
    end else begin
      push_out <= pop_fire;
      if (pop_fire) data_out <= head;
    end
  end

  assign sel           = grant_q;
  assign state_dbg     = state_q;
  assign burst_cnt_dbg = cnt_q;

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Bench for mux_arbiter_rr: queue-backed input FIFOs, a per-cycle reference
// model of the grant/rotation rules, an in-order word scoreboard and
// directed sequences with literal expected output orders.
module tb_mux_arbiter_rr;
  import mux_pkg::*;

  localparam int W     = 12;
  localparam int BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0]   fifo_empty;
  logic [W-1:0] din [4];
  logic         out_almost_full;
  logic [3:0]   pop;
  logic [1:0]   sel;
  logic [W-1:0] data_out;
  logic         push_out;
  state_t       state_dbg;
  logic [3:0]   burst_cnt_dbg;

  mux_arbiter_rr #(.DATA_W(W), .BURST(BURST)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .fifo_empty      (fifo_empty),
    .data_in0        (din[0]),
    .data_in1        (din[1]),
    .data_in2        (din[2]),
    .data_in3        (din[3]),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .sel             (sel),
    .data_out        (data_out),
    .push_out        (push_out),
    .state_dbg       (state_dbg),
    .burst_cnt_dbg   (burst_cnt_dbg)
  );

  // ---------------- bench state ----------------
  logic [W-1:0] fq [4][$];   // contents of the four input FIFOs
  logic [W-1:0] exp_q[$];    // words popped, awaiting push_out
  logic [W-1:0] got_q[$];    // words delivered downstream, in order
  logic [W-1:0] want[$];
  logic [3:0]   pop_s;
  int checks = 0;
  int errors = 0;

  // Reference model: is a port being served, which one, where the next
  // search starts, and how many words the current grant has taken.
  bit           m_serving;
  int           m_owner;
  int           m_ptr;
  int           m_taken;
  bit           m_push;
  logic [W-1:0] m_data;
  logic [3:0]   m_req;
  logic [3:0]   e_pop;
  bit           m_found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    pop_s = pop;
    if (!reset_L) begin
      chk("rst_pop", 32'(pop), 32'd0);
      chk("rst_push", 32'(push_out), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      m_serving = 0; m_owner = 0; m_ptr = 0; m_taken = 0;
      m_push = 0; m_data = '0;
      exp_q.delete();
    end else begin
      m_req = ~fifo_empty;
      e_pop = '0;
      if (m_serving && m_req[m_owner] && !out_almost_full) e_pop[m_owner] = 1'b1;
      chk("pop", 32'(pop), 32'(e_pop));
      chk("sel", 32'(sel), 32'(m_owner));
      chk("push_out", 32'(push_out), 32'(m_push));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("pop_onehot0", 32'($onehot0(pop)), 32'd1);
      chk("pop_of_empty", 32'(pop & fifo_empty), 32'd0);
      if (push_out) begin
        chk("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("sb_word", 32'(data_out), 32'(exp_q.pop_front()));
        got_q.push_back(data_out);
      end
      // advance the model by one clock
      if (!m_serving) begin
        if (m_req != 4'd0 && !out_almost_full) begin
          m_found = 0;
          for (int k = 0; k < 4; k++) begin
            if (!m_found && m_req[(m_ptr + k) % 4]) begin
              m_owner = (m_ptr + k) % 4;
              m_found = 1;
            end
          end
          m_serving = 1;
          m_taken   = 0;
        end
      end else if (!m_req[m_owner]) begin
        m_serving = 0;
        m_ptr     = (m_owner + 1) % 4;
      end else if (e_pop != 4'd0) begin
        m_taken++;
        if (m_taken == BURST) begin
          m_serving = 0;
          m_ptr     = (m_owner + 1) % 4;
        end
      end
      m_push = (e_pop != 4'd0);
      if (e_pop != 4'd0) m_data = din[m_owner];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      din[i]        = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  // One clock: the input FIFOs honour the pops seen before the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (reset_L && pop_s[i] && fq[i].size() != 0) exp_q.push_back(fq[i].pop_front());
    end
    refresh();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_almost_full = 1'b0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() != 0 ||
            exp_q.size() != 0 || state_dbg != IDLE) && n < 400) begin
      cycle();
      n++;
    end
    chk({name, "_drain_done"}, 32'(n < 400), 32'd1);
    cycle();
    cycle();
  endtask

  task automatic check_order(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < got_q.size()) chk({name, "_word"}, 32'(got_q[i]), 32'(want[i]));
    end
  endtask

  task automatic wait_serve_cnt(input string name, input logic [3:0] cnt);
    int n;
    n = 0;
    while (!(state_dbg == SERVE && burst_cnt_dbg == cnt) && n < 50) begin
      cycle();
      n++;
    end
    chk({name, "_reached"}, 32'(n < 50), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_L = 1'b0;
    out_almost_full = 1'b0;
    pop_s = '0;

    // Reset with every FIFO holding a word.
    fq[0].push_back(12'h101); fq[1].push_back(12'h502);
    fq[2].push_back(12'h903); fq[3].push_back(12'hD04);
    refresh();
    repeat (2) @(posedge clk);
    #3 reset_L = 1'b1;
    @(negedge clk);
    chk("post_rst_pop", 32'(pop), 32'd0);
    chk("post_rst_push", 32'(push_out), 32'd0);
    chk("post_rst_data", 32'(data_out), 32'd0);
    drain("t1");
    want = '{12'h101, 12'h502, 12'h903, 12'hD04};
    check_order("t1");

    // One word per port, delivered in port order.
    got_q.delete();
    fq[0].push_back(12'h001); fq[1].push_back(12'h402);
    fq[2].push_back(12'h803); fq[3].push_back(12'hC04);
    refresh();
    drain("t2");
    want = '{12'h001, 12'h402, 12'h803, 12'hC04};
    check_order("t2");

    // Burst limit: 6 words on port 0, 2 on port 1.
    got_q.delete();
    for (int k = 0; k < 6; k++) fq[0].push_back(12'h010 + 12'(k));
    fq[1].push_back(12'h420); fq[1].push_back(12'h421);
    refresh();
    drain("t3");
    want = '{12'h010, 12'h011, 12'h012, 12'h013, 12'h420, 12'h421, 12'h014, 12'h015};
    check_order("t3");

    // Backpressure mid-burst on port 2.
    got_q.delete();
    for (int k = 0; k < 6; k++) fq[2].push_back(12'h8B0 + 12'(k));
    refresh();
    wait_serve_cnt("t4", 4'd1);
    out_almost_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_pop_held", 32'(pop), 32'd0);
      chk("t4_sel", 32'(sel), 32'd2);
      chk("t4_cnt_frozen", 32'(burst_cnt_dbg), 32'd1);
      cycle();
    end
    out_almost_full = 1'b0;
    drain("t4");
    want = '{12'h8B0, 12'h8B1, 12'h8B2, 12'h8B3, 12'h8B4, 12'h8B5};
    check_order("t4");

    // Wrap-around: pointer sits at 3, ports 0 and 3 ready.
    got_q.delete();
    fq[0].push_back(12'h0C0); fq[3].push_back(12'hCC3);
    refresh();
    drain("t5");
    want = '{12'hCC3, 12'h0C0};
    check_order("t5");

    // Asynchronous reset while port 2 has taken two words.
    for (int k = 0; k < 6; k++) fq[2].push_back(12'h860 + 12'(k));
    refresh();
    wait_serve_cnt("t6", 4'd2);
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk("t6_async_pop", 32'(pop), 32'd0);
    chk("t6_async_push", 32'(push_out), 32'd0);
    chk("t6_async_data", 32'(data_out), 32'd0);
    chk("t6_async_sel", 32'(sel), 32'd0);
    got_q.delete();
    fq[0].push_back(12'h0A0); fq[3].push_back(12'hCA3);
    refresh();
    repeat (2) @(posedge clk);
    #3 reset_L = 1'b1;
    drain("t6");
    want = '{12'h0A0, 12'h862, 12'h863, 12'h864, 12'h865, 12'hCA3};
    check_order("t6");

    // Random traffic and random backpressure.
    for (int c = 0; c < 2000; c++) begin
      cycle();
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 9) < 3 && fq[p].size() < 8) fq[p].push_back(12'($urandom));
      end
      out_almost_full = ($urandom_range(0, 4) == 0);
      refresh();
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
